debounce_2: RTL and testbench



---
 rtl/debounce_pkg.sv | 21 ++
 rtl/debounce_ch.sv | 124 ++++++++++++
 rtl/debounce_2.sv | 45 ++++
 tb/tb_debounce_2.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the two-channel debouncer.
// The state encoding is fixed so that bit 1 alone tells whether the clean level is high.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } deb_state_e;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
  // Short debounce window for simulation runs.
  localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;

  function automatic logic state_is_high(deb_state_e st);
    return st[1];
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, stability counter/FSM and edge pulse generator.
// Edge pulses are only built when DEBOUNCE_EDGE_EN is defined; otherwise they are tied low.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debounce_ch: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("debounce_ch: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  deb_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // The clean level is registered alongside the state so it tracks state_is_high(state_q).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      unique case (state_q)
        STABLE_LO: begin
          if (s) begin
            state_q <= WAIT_HI;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
            level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state_q <= WAIT_LO;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        WAIT_LO: begin
          if (s) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= STABLE_LO;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign level_o = level_q;

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q;
  logic fall_q;

  // Pulses fire on the same edge that commits the level, so they line up with its first cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= (state_q == WAIT_HI) && s && (cnt_q == CntLast);
      fall_q <= (state_q == WAIT_LO) && !s && (cnt_q == CntLast);
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_2.sv
// Two-channel switch conditioner feeding the NOR gate's a/b inputs.
// Define DEBOUNCE_EDGE_EN to build the per-channel rise/fall pulse outputs.
module debounce_2
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  debounce_ch #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_ch_a (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .raw_i   (a_raw),
    .level_o (a),
    .rise_o  (a_rise),
    .fall_o  (a_fall)
  );

  debounce_ch #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_ch_b (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .raw_i   (b_raw),
    .level_o (b),
    .rise_o  (b_rise),
    .fall_o  (b_fall)
  );

endmodule

// File: tb/tb_debounce_2.sv
// Scoreboard bench for debounce_2 with SYNC_STAGES=2, DEBOUNCE_CYCLES=4 (latency 6 edges).
// Expected level changes are queued when stimulus is driven; a negedge monitor pops them.
module tb_debounce_2;
  import debounce_pkg::*;

  localparam int unsigned Lat = 2 + DEBOUNCE_CYCLES_SIM;
`ifdef DEBOUNCE_EDGE_EN
  localparam bit EdgeOn = 1'b1;
`else
  localparam bit EdgeOn = 1'b0;
`endif

  typedef struct {
    int unsigned due;
    bit          ch;
    bit          dir;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic a, b, a_rise, a_fall, b_rise, b_fall;

  int unsigned cyc = 0;
  int errors = 0;
  int checks = 0;
  ev_t exp_q[$];
  logic [1:0] prev_lv = 2'b00;

  debounce_2 #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_raw  (a_raw),
    .b_raw  (b_raw),
    .a      (a),
    .b      (b),
    .a_rise (a_rise),
    .a_fall (a_fall),
    .b_rise (b_rise),
    .b_fall (b_fall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every level change must match the queue head; pulses must mark the first new cycle.
  always @(negedge clk) begin
    logic [1:0] lv, rv, fv;
    logic exp_r, exp_f;
    lv = {b, a};
    rv = {b_rise, a_rise};
    fv = {b_fall, a_fall};
    for (int c = 0; c < 2; c++) begin
      if (lv[c] !== prev_lv[c]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_edge ch%0d: got level %b at cycle %0d, required no change",
                   c, lv[c], cyc);
        end else begin
          ev_t ev;
          ev = exp_q.pop_front();
          if (ev.ch !== c[0] || ev.dir !== lv[c] || ev.due != cyc) begin
            errors++;
            $display("FAIL edge_timing: got ch%0d->%b at cycle %0d, required ch%0d->%b at cycle %0d",
                     c, lv[c], cyc, ev.ch, ev.dir, ev.due);
          end
        end
      end
      exp_r = EdgeOn & rst_n & lv[c] & ~prev_lv[c];
      exp_f = EdgeOn & rst_n & ~lv[c] & prev_lv[c];
      checks++;
      if (rv[c] !== exp_r || fv[c] !== exp_f) begin
        errors++;
        $display("FAIL pulse ch%0d at cycle %0d: got rise=%b fall=%b, required rise=%b fall=%b",
                 c, cyc, rv[c], fv[c], exp_r, exp_f);
      end
    end
    prev_lv = lv;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input bit ch, input bit dir, input int unsigned due);
    ev_t ev;
    ev.ch  = ch;
    ev.dir = dir;
    ev.due = due;
    exp_q.push_back(ev);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected edges still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({a, b, a_rise, a_fall, b_rise, b_fall} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs: got %b, required 000000",
                 {a, b, a_rise, a_fall, b_rise, b_fall});
      end
    end
    rst_n = 1'b1;
    wait_cycles(4);
    checks++;
    if ({a, b} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: got a=%b b=%b, required 0 0", a, b);
    end
  endtask

  task automatic test_press;
    @(negedge clk);
    a_raw = 1'b1;
    push_ev(1'b0, 1'b1, cyc + Lat);
    wait_cycles(10);
    check_drained("press");
    checks++;
    if (a !== 1'b1 || b !== 1'b0) begin
      errors++;
      $display("FAIL press_level: got a=%b b=%b, required 1 0", a, b);
    end
  endtask

  task automatic test_release;
    @(negedge clk);
    a_raw = 1'b0;
    push_ev(1'b0, 1'b0, cyc + Lat);
    wait_cycles(10);
    check_drained("release");
    checks++;
    if (a !== 1'b0) begin
      errors++;
      $display("FAIL release_level: got a=%b, required 0", a);
    end
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_raw = (i % 2 == 0);
      @(negedge clk);
    end
    wait_cycles(12);
    check_drained("bounce");
    checks++;
    if (a !== 1'b0) begin
      errors++;
      $display("FAIL bounce_level: got a=%b, required 0", a);
    end
  endtask

  task automatic test_simultaneous;
    @(negedge clk);
    a_raw = 1'b1;
    b_raw = 1'b1;
    push_ev(1'b0, 1'b1, cyc + Lat);
    push_ev(1'b1, 1'b1, cyc + Lat);
    wait_cycles(10);
    check_drained("simultaneous_rise");
    checks++;
    if ({a, b} !== 2'b11) begin
      errors++;
      $display("FAIL simultaneous_level: got a=%b b=%b, required 1 1", a, b);
    end
    @(negedge clk);
    b_raw = 1'b0;
    wait_cycles(3);
    b_raw = 1'b1;
    wait_cycles(12);
    check_drained("b_glitch");
    checks++;
    if (b !== 1'b1) begin
      errors++;
      $display("FAIL b_glitch_level: got b=%b, required 1", b);
    end
    @(negedge clk);
    a_raw = 1'b0;
    b_raw = 1'b0;
    push_ev(1'b0, 1'b0, cyc + Lat);
    push_ev(1'b1, 1'b0, cyc + Lat);
    wait_cycles(10);
    check_drained("simultaneous_fall");
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    a_raw = 1'b1;
    wait_cycles(4);
    rst_n = 1'b0;
    #1;
    checks++;
    if (a !== 1'b0 || a_rise !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_abort: got a=%b a_rise=%b, required 0 0", a, a_rise);
    end
    wait_cycles(2);
    rst_n = 1'b1;
    push_ev(1'b0, 1'b1, cyc + Lat);
    wait_cycles(Lat - 1);
    checks++;
    if (a !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_early: got a=%b one edge before full latency, required 0", a);
    end
    wait_cycles(1);
    checks++;
    if (a !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_late: got a=%b at full latency, required 1", a);
    end
    wait_cycles(3);
    check_drained("mid_reset_rise");
    // Asynchronous clear of a settled high level, away from any clock edge.
    @(negedge clk);
    push_ev(1'b0, 1'b0, cyc + 1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: got a=%b before next clock edge, required 0", a);
    end
    wait_cycles(2);
    rst_n = 1'b1;
    push_ev(1'b0, 1'b1, cyc + Lat);
    wait_cycles(10);
    check_drained("async_clear_recover");
    @(negedge clk);
    a_raw = 1'b0;
    push_ev(1'b0, 1'b0, cyc + Lat);
    wait_cycles(10);
    check_drained("mid_reset_cleanup");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
